// File: rtl/mfcc_amp_pkg.sv
// -----------------------------------------------------------------------------
// mfcc_amp_pkg
// Shared definitions for the amplitude/magnitude stage controllers.
//   - state_e       : min-search controller FSM states
//   - EXP_*/MAN_*   : IEEE-754 single-precision field positions
//   - CMP_LATENCY_DEF : latency of the shared min comparator
//   - idx_width()   : index width for a given frame length (never zero)
// -----------------------------------------------------------------------------
package mfcc_amp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCEPT  = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_e;

  // IEEE-754 single field positions; bit 31 (sign) is not part of magnitude
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_MSB = 22;

  // Rising edges from operand change to valid comparator result
  localparam int CMP_LATENCY_DEF = 3;

  // Index field width; a 1-sample frame still needs a 1-bit field
  function automatic int idx_width(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/min_search_ctrl.sv
// -----------------------------------------------------------------------------
// min_search_ctrl
// Reduces a streamed frame of IEEE-754 magnitudes to its minimum word and the
// index of that word, using an external (shared) multi-cycle min comparator.
//
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid/in_ready   : sample handshake; in_data sample, in_last frame end
//   cmp_a, cmp_b        : comparator operands (running min, candidate),
//                         held stable while the comparator works
//   cmp_result          : comparator output, returns cmp_a on a tie
//   out_valid/out_ready : result handshake; out_valid held until out_ready
//   out_min, out_index  : minimum word (bit-exact) and its zero-based index
//   out_count           : samples in the frame
//   out_trunc           : frame ended at MAX_LEN without in_last
//   busy                : frame in progress
// -----------------------------------------------------------------------------
module min_search_ctrl
  import mfcc_amp_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_LEN     = 64,
  parameter int CMP_LATENCY = CMP_LATENCY_DEF,
  parameter int IDX_W       = idx_width(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] cmp_a,
  output logic [DATA_WIDTH-1:0] cmp_b,
  input  logic [DATA_WIDTH-1:0] cmp_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_min,
  output logic [IDX_W-1:0]      out_index,
  output logic [IDX_W:0]        out_count,
  output logic                  out_trunc,
  output logic                  busy
);

  localparam int CNT_W  = IDX_W + 1;
  localparam int WCNT_W = (CMP_LATENCY > 1) ? $clog2(CMP_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_LEN);
  localparam logic [WCNT_W-1:0] WAIT_END = WCNT_W'(CMP_LATENCY - 1);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_min;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        r_cand_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [WCNT_W-1:0]       r_wcnt;
  logic                    r_last;
  logic                    r_trunc;

  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_hit_max;
  logic                    w_first_done;
  logic                    w_first_trunc;
  logic                    w_keep_min;
  logic [IDX_W-1:0]        w_cap_idx;

  assign in_ready = (r_state == IDLE) || (r_state == ACCEPT);
  assign busy     = (r_state != IDLE);

  // Counter bound, tie detection and captured index selection
  always_comb begin
    w_cnt_inc     = r_cnt + CNT_W'(1);
    w_hit_max     = (w_cnt_inc == MAX_CNT);
    // A one-sample frame needs no comparison at all
    w_first_done  = in_last || (MAX_LEN == 1);
    w_first_trunc = (MAX_LEN == 1) && !in_last;
    // Comparator echoes cmp_a on ties, so equality means the old minimum stays
    w_keep_min    = (cmp_result == cmp_a);
    if (w_keep_min) begin
      w_cap_idx = r_idx;
    end else begin
      w_cap_idx = r_cand_idx;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_first_done) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = ACCEPT;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = ACCEPT;
        end
      end
      WAIT: begin
        if (r_wcnt == WAIT_END) begin
          w_state_nxt = CAPTURE;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      CAPTURE: begin
        if (r_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = ACCEPT;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: running minimum, counters, comparator operands, result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min      <= '0;
      r_idx      <= '0;
      r_cand_idx <= '0;
      r_cnt      <= '0;
      r_wcnt     <= '0;
      r_last     <= 1'b0;
      r_trunc    <= 1'b0;
      cmp_a      <= '0;
      cmp_b      <= '0;
      out_valid  <= 1'b0;
      out_min    <= '0;
      out_index  <= '0;
      out_count  <= '0;
      out_trunc  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_min   <= in_data;
            r_idx   <= '0;
            r_cnt   <= CNT_W'(1);
            r_trunc <= w_first_trunc;
            if (w_first_done) begin
              out_valid <= 1'b1;
              out_min   <= in_data;
              out_index <= '0;
              out_count <= CNT_W'(1);
              out_trunc <= w_first_trunc;
            end
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            cmp_a      <= r_min;
            cmp_b      <= in_data;
            r_cand_idx <= r_cnt[IDX_W-1:0];
            r_cnt      <= w_cnt_inc;
            r_last     <= in_last || w_hit_max;
            r_trunc    <= !in_last && w_hit_max;
            r_wcnt     <= '0;
          end
        end
        WAIT: begin
          r_wcnt <= r_wcnt + WCNT_W'(1);
        end
        CAPTURE: begin
          r_min <= cmp_result;
          r_idx <= w_cap_idx;
          if (r_last) begin
            out_valid <= 1'b1;
            out_min   <= cmp_result;
            out_index <= w_cap_idx;
            out_count <= r_cnt;
            out_trunc <= r_trunc;
          end
        end
        DONE: begin
          // Result fields return to zero once the result has been taken
          if (out_ready) begin
            out_valid <= 1'b0;
            out_min   <= '0;
            out_index <= '0;
            out_count <= '0;
            out_trunc <= 1'b0;
          end
        end
        default: begin
          r_wcnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_min_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_min_search_ctrl
// Self-checking bench for min_search_ctrl (MAX_LEN = 4 so truncation is
// reachable). A 3-stage magnitude-min comparator is modelled beside the DUT.
// Expected results come from a frame-level reference: collect the samples of
// a frame, pick the earliest smallest magnitude.
// -----------------------------------------------------------------------------
module tb_min_search_ctrl;

  localparam int DW = 32;
  localparam int ML = 4;
  localparam int CL = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [DW-1:0] cmp_a;
  logic [DW-1:0] cmp_b;
  logic [DW-1:0] cmp_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_min;
  logic [IW-1:0] out_index;
  logic [IW:0]   out_count;
  logic          out_trunc;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  min_search_ctrl #(
    .DATA_WIDTH (DW),
    .MAX_LEN    (ML),
    .CMP_LATENCY(CL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_result(cmp_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_index (out_index),
    .out_count (out_count),
    .out_trunc (out_trunc),
    .busy      (busy)
  );

  // Shared comparator: smaller magnitude (sign ignored), cmp_a on tie, 3 edges
  logic [DW-1:0] p1, p2, p3;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= '0; p2 <= '0; p3 <= '0;
    end else begin
      p1 <= (cmp_b[30:0] < cmp_a[30:0]) ? cmp_b : cmp_a;
      p2 <= p1;
      p3 <= p2;
    end
  end
  assign cmp_result = p3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Operands must hold while the comparator is working (busy, not ready, no result)
  logic [DW-1:0] prev_a, prev_b;
  bit in_wc = 1'b0;
  always @(negedge clk) begin
    if (busy && !in_ready && !out_valid && !rst) begin
      if (in_wc) begin
        chk("cmp_a_stable", cmp_a, prev_a);
        chk("cmp_b_stable", cmp_b, prev_b);
      end
      prev_a = cmp_a;
      prev_b = cmp_b;
      in_wc  = 1'b1;
    end else begin
      in_wc = 1'b0;
    end
  end

  logic [DW-1:0] sd[$];
  bit            sl[$];
  logic [DW-1:0] fr[$];

  task automatic push(input logic [DW-1:0] d, input bit l, output int acc_cyc);
    int t;
    t = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) chk("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic expect_frame(input int first_acc, input int last_acc, input bit gapless,
                              input bit trunc, input int hold);
    int best, t, n;
    logic [DW-1:0] emin;
    n = fr.size();
    best = 0;
    for (int i = 1; i < n; i++) begin
      if (fr[i][30:0] < fr[best][30:0]) best = i;
    end
    emin = fr[best];
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("result_timeout", 32'd0, 32'd1);
    chk("lat_from_last", 32'(cyc - last_acc), (n > 1) ? 32'(CL + 1) : 32'd0);
    if (gapless) chk("lat_from_first", 32'(cyc - first_acc), 32'((n - 1) * (CL + 2)));
    chk("out_min", out_min, emin);
    chk("out_index", 32'(out_index), 32'(best));
    chk("out_count", 32'(out_count), 32'(n));
    chk("out_trunc", 32'(out_trunc), 32'(trunc));
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_min", out_min, emin);
      chk("hold_index", 32'(out_index), 32'(best));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    fr.delete();
  endtask

  // Drives sd/sl; frames close on in_last or on reaching ML samples
  task automatic run_stream(input int gap_max, input int hold);
    int first_acc, acc, g;
    first_acc = 0;
    for (int i = 0; i < sd.size(); i++) begin
      if (gap_max > 0) begin
        g = $urandom_range(gap_max, 0);
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
      push(sd[i], sl[i], acc);
      if (fr.size() == 0) first_acc = acc;
      fr.push_back(sd[i]);
      if (sl[i] || fr.size() == ML) expect_frame(first_acc, acc, gap_max == 0, !sl[i], hold);
    end
    sd.delete();
    sl.delete();
  endtask

  initial begin
    int acc, len;
    logic [DW-1:0] v;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_min", out_min, 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_cmp_a", cmp_a, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-sample frame: no comparator activity
    sd = '{32'h3F80_0000}; sl = '{1'b1};
    run_stream(0, 0);
    chk("single_no_cmp_a", cmp_a, 32'd0);
    chk("single_no_cmp_b", cmp_b, 32'd0);

    // Four-sample frame, back-to-back
    sd = '{32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h3E80_0000};
    sl = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_stream(0, 0);

    // Tie across sign: earliest index wins
    sd = '{32'h3F00_0000, 32'hBF00_0000, 32'h3F00_0000};
    sl = '{1'b0, 1'b0, 1'b1};
    run_stream(0, 0);

    // Truncation at ML plus 10-cycle backpressure; 0.5 opens the next frame
    sd = '{32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000,
           32'h3F00_0000, 32'h4000_0000};
    sl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_stream(0, 10);

    // Asynchronous reset while sample 2 is in WAIT
    push(32'h3F80_0000, 1'b0, acc);
    push(32'h3F00_0000, 1'b0, acc);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cmp_a", cmp_a, 32'd0);
    chk("arst_cmp_b", cmp_b, 32'd0);
    chk("arst_out_min", out_min, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sd = '{32'h3F80_0000, 32'h3F00_0000}; sl = '{1'b0, 1'b1};
    run_stream(0, 0);

    // Random frames with stalls, ties and sign flips
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(6, 1);
      for (int k = 0; k < len; k++) begin
        if (k > 0 && $urandom_range(3, 0) == 0) begin
          v = sd[$urandom_range(k - 1, 0)];
          v[31] = 1'($urandom_range(1, 0));
        end else begin
          v = {1'($urandom_range(1, 0)), 8'($urandom_range(130, 120)),
               ($urandom_range(1, 0) == 0) ? 23'h0 : 23'($urandom)};
        end
        sd.push_back(v);
        sl.push_back(k == len - 1);
      end
      run_stream(3, $urandom_range(2, 0));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
